// File: rtl/uart_rx_fifo_if.sv
// Bus bundle between the UART receive path / CPU I/O port and the receive FIFO.
// The master side supplies received bytes and CPU read strobes; the slave side
// is the FIFO, which returns read data and status.
interface uart_rx_fifo_if #(
   parameter int DATA_W     = 8,
   parameter int DEPTH_LOG2 = 4
);
   logic [DATA_W-1:0]     rx_data;
   logic                  rx_valid;
   logic                  io_rd;
   logic [1:0]            io_addr;
   logic [DATA_W-1:0]     io_dout;
   logic                  rx_ready;
   logic                  overrun;
   logic [DEPTH_LOG2:0]   level;

   modport master (
      output rx_data, rx_valid, io_rd, io_addr,
      input  io_dout, rx_ready, overrun, level
   );

   modport slave (
      input  rx_data, rx_valid, io_rd, io_addr,
      output io_dout, rx_ready, overrun, level
   );
endinterface

// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO between the UART receiver and the CPU I/O bus.
// Bytes arrive as one-cycle strobes and are buffered in a circular array; the
// CPU drains them and reads status through a 2-bit register window:
//   0 = DATA (pops), 1 = STATUS {overrun, full, non-empty}, 2 = LEVEL, 3 = 0.
module uart_rx_fifo #(
   parameter int DATA_W     = 8,
   parameter int DEPTH_LOG2 = 4
) (
   input logic             clk,
   input logic             rst,
   uart_rx_fifo_if.slave   bus
);
   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] CNT_FULL = (DEPTH_LOG2+1)'(DEPTH);

   logic [DATA_W-1:0]     mem [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
   logic [DEPTH_LOG2:0]   count, count_nxt;
   logic                  overrun_q, rx_ready_q;
   logic [DATA_W-1:0]     dout_q, rd_data;
   logic                  full, empty, pop, push, drop, stat_rd;

   assign full    = (count == CNT_FULL);
   assign empty   = (count == '0);
   // A pop needs stored data; a same-cycle push into an empty FIFO is not bypassed.
   assign pop     = bus.io_rd && (bus.io_addr == 2'd0) && !empty;
   // A full FIFO still accepts a byte when a pop frees a slot on the same edge.
   assign push    = bus.rx_valid && (!full || pop);
   assign drop    = bus.rx_valid && full && !pop;
   assign stat_rd = bus.io_rd && (bus.io_addr == 2'd1);

   // Next occupancy: simultaneous push and pop leave it unchanged.
   always_comb begin
      count_nxt = count;
      case ({push, pop})
         2'b10:   count_nxt = count + 1'b1;
         2'b01:   count_nxt = count - 1'b1;
         default: count_nxt = count;
      endcase
   end

   // Register-window read mux; empty DATA reads return 0.
   always_comb begin
      rd_data = '0;
      case (bus.io_addr)
         2'd0: if (!empty) rd_data = mem[rd_ptr];
         2'd1: rd_data[2:0] = {overrun_q, full, !empty};
         2'd2: rd_data = DATA_W'(count);
         default: rd_data = '0;
      endcase
   end

   // Storage array: no reset, stale entries are unreachable behind the pointers.
   always_ff @(posedge clk) begin
      if (!rst && push) mem[wr_ptr] <= bus.rx_data;
   end

   // Pointers, occupancy, sticky overrun and registered read data.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         overrun_q  <= 1'b0;
         rx_ready_q <= 1'b0;
         dout_q     <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         count      <= count_nxt;
         rx_ready_q <= (count_nxt != '0);
         if (bus.io_rd) dout_q <= rd_data;
         // Clear-on-read loses to a drop on the same edge.
         if (stat_rd) overrun_q <= 1'b0;
         if (drop)    overrun_q <= 1'b1;
      end
   end

   assign bus.io_dout  = dout_q;
   assign bus.rx_ready = rx_ready_q;
   assign bus.overrun  = overrun_q;
   assign bus.level    = count;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: a vector table for the basic register window,
// then hand-written sequences for overrun, full/empty collisions, wrap and reset.
module tb_uart_rx_fifo;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   uart_rx_fifo_if #(.DATA_W(8), .DEPTH_LOG2(4)) bus ();
   uart_rx_fifo #(.DATA_W(8), .DEPTH_LOG2(4)) dut (.clk(clk), .rst(rst), .bus(bus));

   typedef struct {
      logic       rst;
      logic       rx_valid;
      logic [7:0] rx_data;
      logic       io_rd;
      logic [1:0] io_addr;
      logic [7:0] exp_dout;
      logic [4:0] exp_level;
      logic       exp_ready;
      logic       exp_ovr;
   } vec_t;

   vec_t vecs[14];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic r, input logic v, input logic [7:0] d,
                        input logic rd, input logic [1:0] a);
      rst = r; bus.rx_valid = v; bus.rx_data = d; bus.io_rd = rd; bus.io_addr = a;
      @(posedge clk);
      #1;
      rst = 1'b0; bus.rx_valid = 1'b0; bus.io_rd = 1'b0; bus.io_addr = 2'd0;
   endtask

   task automatic push(input logic [7:0] d);
      drive(1'b0, 1'b1, d, 1'b0, 2'd0);
   endtask

   task automatic rd(input logic [1:0] a, output logic [7:0] d);
      drive(1'b0, 1'b0, 8'h00, 1'b1, a);
      d = bus.io_dout;
   endtask

   initial begin
      logic [7:0] d;
      logic [7:0] q[$];
      logic [7:0] e;

      bus.rx_valid = 1'b0; bus.rx_data = '0; bus.io_rd = 1'b0; bus.io_addr = '0;

      //          rst  v     data   rd    addr  dout   lvl    rdy   ovr
      vecs[0]  = '{1'b1, 1'b0, 8'h00, 1'b0, 2'd0, 8'h00, 5'd0, 1'b0, 1'b0};
      vecs[1]  = '{1'b0, 1'b1, 8'h41, 1'b0, 2'd0, 8'h00, 5'd1, 1'b1, 1'b0};
      vecs[2]  = '{1'b0, 1'b1, 8'h42, 1'b0, 2'd0, 8'h00, 5'd2, 1'b1, 1'b0};
      vecs[3]  = '{1'b0, 1'b1, 8'h43, 1'b0, 2'd0, 8'h00, 5'd3, 1'b1, 1'b0};
      vecs[4]  = '{1'b0, 1'b0, 8'h00, 1'b1, 2'd0, 8'h41, 5'd2, 1'b1, 1'b0};
      vecs[5]  = '{1'b0, 1'b0, 8'h00, 1'b1, 2'd0, 8'h42, 5'd1, 1'b1, 1'b0};
      vecs[6]  = '{1'b0, 1'b0, 8'h00, 1'b1, 2'd0, 8'h43, 5'd0, 1'b0, 1'b0};
      vecs[7]  = '{1'b0, 1'b0, 8'h00, 1'b0, 2'd0, 8'h43, 5'd0, 1'b0, 1'b0};
      vecs[8]  = '{1'b0, 1'b0, 8'h00, 1'b1, 2'd3, 8'h00, 5'd0, 1'b0, 1'b0};
      vecs[9]  = '{1'b0, 1'b1, 8'h5A, 1'b0, 2'd0, 8'h00, 5'd1, 1'b1, 1'b0};
      vecs[10] = '{1'b0, 1'b0, 8'h00, 1'b1, 2'd2, 8'h01, 5'd1, 1'b1, 1'b0};
      vecs[11] = '{1'b0, 1'b0, 8'h00, 1'b1, 2'd1, 8'h01, 5'd1, 1'b1, 1'b0};
      vecs[12] = '{1'b0, 1'b0, 8'h00, 1'b1, 2'd0, 8'h5A, 5'd0, 1'b0, 1'b0};
      vecs[13] = '{1'b0, 1'b0, 8'h00, 1'b1, 2'd0, 8'h00, 5'd0, 1'b0, 1'b0};

      @(posedge clk); #1;
      for (int i = 0; i < 14; i++) begin
         drive(vecs[i].rst, vecs[i].rx_valid, vecs[i].rx_data, vecs[i].io_rd, vecs[i].io_addr);
         check($sformatf("vec%0d dout", i), bus.io_dout, vecs[i].exp_dout);
         check($sformatf("vec%0d level", i), bus.level, vecs[i].exp_level);
         check($sformatf("vec%0d ready", i), bus.rx_ready, vecs[i].exp_ready);
         check($sformatf("vec%0d overrun", i), bus.overrun, vecs[i].exp_ovr);
      end

      // Fill, overflow by one, STATUS read clears overrun, drain in order.
      drive(1'b1, 1'b0, 8'h00, 1'b0, 2'd0);
      for (int i = 0; i < 16; i++) push(8'(i));
      check("full level", bus.level, 16);
      push(8'hAA);
      check("ovf level", bus.level, 16);
      check("ovf flag", bus.overrun, 1);
      rd(2'd1, d);
      check("status full+ovr", d, 8'h07);
      check("ovr cleared", bus.overrun, 0);
      for (int i = 0; i < 16; i++) begin
         rd(2'd0, d);
         check($sformatf("drain%0d", i), d, 8'(i));
      end
      rd(2'd1, d);
      check("status after drain", d, 8'h00);

      // Full FIFO with simultaneous push and pop.
      drive(1'b1, 1'b0, 8'h00, 1'b0, 2'd0);
      for (int i = 0; i < 16; i++) push(8'(8'h10 + i));
      drive(1'b0, 1'b1, 8'h55, 1'b1, 2'd0);
      check("full pp dout", bus.io_dout, 8'h10);
      check("full pp level", bus.level, 16);
      check("full pp ovr", bus.overrun, 0);
      for (int i = 0; i < 16; i++) begin
         e = (i == 15) ? 8'h55 : 8'(8'h11 + i);
         rd(2'd0, d);
         check($sformatf("full pp drain%0d", i), d, e);
      end

      // Empty FIFO with simultaneous push and pop: no bypass.
      push(8'h99);
      rd(2'd0, d);
      check("pre empty pp", d, 8'h99);
      drive(1'b0, 1'b1, 8'h77, 1'b1, 2'd0);
      check("empty pp dout", bus.io_dout, 8'h00);
      check("empty pp level", bus.level, 1);
      rd(2'd0, d);
      check("empty pp next", d, 8'h77);

      // Interleaved pushes and pops so the pointers wrap.
      drive(1'b1, 1'b0, 8'h00, 1'b0, 2'd0);
      for (int i = 0; i < 10; i++) begin push(8'(8'h80 + i)); q.push_back(8'(8'h80 + i)); end
      for (int i = 0; i < 8; i++) begin rd(2'd0, d); e = q.pop_front(); check($sformatf("wrapA%0d", i), d, e); end
      for (int i = 0; i < 10; i++) begin push(8'(8'hC0 + i)); q.push_back(8'(8'hC0 + i)); end
      for (int i = 0; i < 12; i++) begin rd(2'd0, d); e = q.pop_front(); check($sformatf("wrapB%0d", i), d, e); end
      check("wrap level", bus.level, 0);
      check("wrap ovr", bus.overrun, 0);

      // Reset mid-transfer discards buffered bytes and the strobe in that cycle.
      for (int i = 0; i < 5; i++) push(8'(8'h30 + i));
      rd(2'd0, d);
      check("pre rst read", d, 8'h30);
      drive(1'b1, 1'b1, 8'hEE, 1'b0, 2'd0);
      check("rst level", bus.level, 0);
      check("rst ready", bus.rx_ready, 0);
      check("rst ovr", bus.overrun, 0);
      check("rst dout", bus.io_dout, 0);
      rd(2'd0, d);
      check("rst read", d, 8'h00);
      check("rst read level", bus.level, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
